// File: rtl/bitonic_pkg.sv
// Shared types for the bitonic compare-exchange network: output-buffer state
// and the key/tag pair carried between stages.
package bitonic_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    localparam int unsigned PAIR_KEY_W = 8;
    localparam int unsigned PAIR_TAG_W = 4;

    // Default-width pair; width-parameterised stages declare a local type with this layout.
    typedef struct packed {
        logic [PAIR_KEY_W-1:0] key_a;
        logic [PAIR_KEY_W-1:0] key_b;
        logic [PAIR_TAG_W-1:0] tag_a;
        logic [PAIR_TAG_W-1:0] tag_b;
        logic                  swapped;
    } pair_t;

endpackage

// File: rtl/bitonic_cx_core.sv
// Combinational compare-exchange: orders one key pair by polarity, tags follow
// their keys, equal keys stay in place.
module bitonic_cx_core #(
    parameter int unsigned KEY_W  = 8,
    parameter int unsigned TAG_W  = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic [KEY_W-1:0] i_key_a,
    input  logic [KEY_W-1:0] i_key_b,
    input  logic [TAG_W-1:0] i_tag_a,
    input  logic [TAG_W-1:0] i_tag_b,
    input  logic             i_polarity,
    output logic [KEY_W-1:0] o_key_a,
    output logic [KEY_W-1:0] o_key_b,
    output logic [TAG_W-1:0] o_tag_a,
    output logic [TAG_W-1:0] o_tag_b,
    output logic             o_swap
);

    logic w_a_gt_b;
    logic w_a_lt_b;

    always_comb begin
        if (SIGNED) begin
            w_a_gt_b = $signed(i_key_a) > $signed(i_key_b);
            w_a_lt_b = $signed(i_key_a) < $signed(i_key_b);
        end else begin
            w_a_gt_b = i_key_a > i_key_b;
            w_a_lt_b = i_key_a < i_key_b;
        end
        o_swap  = i_polarity ? w_a_lt_b : w_a_gt_b;
        o_key_a = o_swap ? i_key_b : i_key_a;
        o_key_b = o_swap ? i_key_a : i_key_b;
        o_tag_a = o_swap ? i_tag_b : i_tag_a;
        o_tag_b = o_swap ? i_tag_a : i_tag_b;
    end

endmodule

// File: rtl/bitonic_cx_node.sv
// Registered compare-exchange node with a main+skid elastic output buffer
// and a saturating swap counter.
module bitonic_cx_node
    import bitonic_pkg::*;
#(
    parameter int unsigned KEY_W  = 8,
    parameter int unsigned TAG_W  = 4,
    parameter bit          SIGNED = 1'b0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] in_key_a,
    input  logic [KEY_W-1:0] in_key_b,
    input  logic [TAG_W-1:0] in_tag_a,
    input  logic [TAG_W-1:0] in_tag_b,
    input  logic             in_polarity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] out_key_a,
    output logic [KEY_W-1:0] out_key_b,
    output logic [TAG_W-1:0] out_tag_a,
    output logic [TAG_W-1:0] out_tag_b,
    output logic             out_swapped,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] swap_count
);

    typedef struct packed {
        logic [KEY_W-1:0] key_a;
        logic [KEY_W-1:0] key_b;
        logic [TAG_W-1:0] tag_a;
        logic [TAG_W-1:0] tag_b;
        logic             swapped;
    } slot_t;

    buf_state_t       r_state;
    buf_state_t       w_state_nx;
    slot_t            r_main;
    slot_t            r_skid;
    slot_t            w_in_slot;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_swap_count;

    logic [KEY_W-1:0] w_key_a;
    logic [KEY_W-1:0] w_key_b;
    logic [TAG_W-1:0] w_tag_a;
    logic [TAG_W-1:0] w_tag_b;
    logic             w_swap;
    logic             w_accept;
    logic             w_pop;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_skid_to_main;

    bitonic_cx_core #(
        .KEY_W  (KEY_W),
        .TAG_W  (TAG_W),
        .SIGNED (SIGNED)
    ) u_core (
        .i_key_a    (in_key_a),
        .i_key_b    (in_key_b),
        .i_tag_a    (in_tag_a),
        .i_tag_b    (in_tag_b),
        .i_polarity (in_polarity),
        .o_key_a    (w_key_a),
        .o_key_b    (w_key_b),
        .o_tag_a    (w_tag_a),
        .o_tag_b    (w_tag_b),
        .o_swap     (w_swap)
    );

    always_comb begin
        w_in_slot.key_a   = w_key_a;
        w_in_slot.key_b   = w_key_b;
        w_in_slot.tag_a   = w_tag_a;
        w_in_slot.tag_b   = w_tag_b;
        w_in_slot.swapped = w_swap;
    end

    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = (r_state != BUF_EMPTY) && out_ready;

    always_comb begin
        w_state_nx     = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (w_accept) begin
                    w_state_nx  = BUF_ONE;
                    w_load_main = 1'b1;
                end
            end
            BUF_ONE: begin
                // Accept without pop can only mean out_ready is low: park the new pair.
                if (w_accept && w_pop) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_state_nx  = BUF_FULL;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nx  = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (w_pop) begin
                    w_state_nx     = BUF_ONE;
                    w_skid_to_main = 1'b1;
                end
            end
            default: w_state_nx = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BUF_EMPTY;
            r_in_ready <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_in_ready <= (w_state_nx != BUF_FULL);
            if (w_load_main) begin
                r_main <= w_in_slot;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_slot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_swap_count <= '0;
        end else if (w_accept && w_swap && (r_swap_count != '1)) begin
            r_swap_count <= r_swap_count + 1'b1;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != BUF_EMPTY);
    assign out_key_a   = r_main.key_a;
    assign out_key_b   = r_main.key_b;
    assign out_tag_a   = r_main.tag_a;
    assign out_tag_b   = r_main.tag_b;
    assign out_swapped = r_main.swapped;
    assign swap_count  = r_swap_count;

endmodule

// File: doc/bitonic_cx_node.md
BITONIC_CX_NODE -- requirements
Module: bitonic_cx_node

Interface
REQ-001 SHALL have parameter KEY_W, default 8, meaning key width in bits (min 1).
REQ-002 SHALL have parameter TAG_W, default 4, meaning payload tag width carried with each key (min 1).
REQ-003 SHALL have parameter SIGNED, default 0, meaning 1 = keys compared as two's complement, 0 = unsigned.
REQ-004 SHALL have parameter CNT_W, default 16, meaning swap-counter width.
REQ-005 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: in_valid  in  1; in_ready  out  1  (input handshake).
REQ-008 SHALL have ports: in_key_a, in_key_b  in  KEY_W each; in_tag_a, in_tag_b  in  TAG_W each.
REQ-009 SHALL have ports: in_polarity  in  1  (1 = descending pair, 0 = ascending pair), sampled with the data.
REQ-010 SHALL have ports: out_valid  out  1; out_ready  in  1  (output handshake).
REQ-011 SHALL have ports: out_key_a, out_key_b  out  KEY_W; out_tag_a, out_tag_b  out  TAG_W; out_swapped  out  1.
REQ-012 SHALL have ports: cnt_clr  in  1; swap_count  out  CNT_W.

Function
REQ-013 SHALL accept a pair on a cycle where in_valid && in_ready; SHALL present a result on a cycle where out_valid && out_ready.
REQ-014 SHALL define the swap decision: polarity 0 → swap iff key_a > key_b; polarity 1 → swap iff key_a < key_b; equal keys never swap (stable).
REQ-015 SHALL move each tag with its key; out_swapped SHALL be 1 iff the pair was exchanged.
REQ-016 SHALL compare per SIGNED; a signed compare of 8'h80 vs 8'h01 SHALL treat 8'h80 as smaller.
REQ-017 SHALL register the compare result: latency from accept to out_valid SHALL be exactly 1 cycle when the output stage is empty or draining.
REQ-018 SHALL contain a 2-entry elastic buffer (main register + skid register); in_ready SHALL be a registered signal, high iff the skid entry is empty.
REQ-019 SHALL sustain one pair per cycle with out_ready held high; no bubbles after the first result.
REQ-020 SHALL, when out_ready falls while accepting, capture the in-flight pair in the skid entry and deassert in_ready on the next cycle; no pair is lost or duplicated.
REQ-021 SHALL preserve pair order through the buffer (FIFO order).
REQ-022 SHALL hold out_* stable while out_valid && !out_ready.
REQ-023 SHALL ignore in_key/tag/polarity when in_valid is low or in_ready is low.
REQ-024 SHALL increment swap_count by 1 on each accepted pair whose decision is swap; count SHALL saturate at 2^CNT_W-1, never wrap.
REQ-025 SHALL clear swap_count to 0 on cnt_clr; cnt_clr and a swap in the same cycle SHALL yield 0 (clear wins).
REQ-026 SHALL implement buffer states EMPTY (0 entries), ONE (main valid), FULL (main+skid valid); transitions: EMPTY→ONE on accept; ONE→FULL on accept && !out_ready; ONE→EMPTY on pop && !accept; FULL→ONE on pop; other combinations hold state.

Reset
REQ-027 SHALL, while rst is high, force out_valid=0, out_swapped=0, swap_count=0, in_ready=0, state EMPTY; out_key/out_tag SHALL reset to 0.
REQ-028 SHALL raise in_ready on the first cycle after rst deasserts.
REQ-029 SHALL discard any buffered pairs on rst asserted mid-operation; no result for them SHALL appear afterwards.

Structure
REQ-030 SHALL place the buffer-state enum and a pair struct typedef (key_a, key_b, tag_a, tag_b, swapped) in shared package bitonic_pkg.
REQ-031 SHALL isolate the comparator + swap mux in combinational sub-module bitonic_cx_core, reused by later network stages.

Verification
REQ-032 SHALL cover: polarity 0, a=8'h30/t1, b=8'h10/t2 → out a=8'h10/t2, b=8'h30/t1, out_swapped=1, one cycle after accept.
REQ-033 SHALL cover: polarity 1, a=b=8'h55 → no swap, tags unchanged, swap_count unchanged.
REQ-034 SHALL cover: SIGNED=1, polarity 0, a=8'h01, b=8'h80 → swap, out a=8'h80; SIGNED=0 same stimulus → no swap.
REQ-035 SHALL cover: 100 back-to-back pairs with random out_ready (50%) → all 100 emerge in order, none lost, in_ready low only when FULL.
REQ-036 SHALL cover: CNT_W=4, 20 swapping pairs → swap_count=15; cnt_clr concurrent with a swap → 0.
REQ-037 SHALL cover: rst asserted with state FULL → next cycle out_valid=0, in_ready=0; the following cycle in_ready=1, and no stale output appears.
